// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg
//   Shared types and helpers for the N-port cacheline memory arbiter.
//   arb_state_t : transaction FSM state (idle / transaction in flight)
//   arb_op_t    : operation latched at grant time
//   arb_idx_width(n) : width of a port index, never less than 1 bit
package mem_arbiter_rr_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef enum logic [1:0] {ARB_OP_NONE, ARB_OP_READ, ARB_OP_WRITE} arb_op_t;

    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker
//   Combinational winner selection for the memory arbiter.
//   Round-robin: first requester found scanning upward from (last+1) mod N.
//   Fixed:       lowest requesting index.
// Ports
//   req   in  N      per-port request (read | write)
//   last  in  IDX_W  most recently granted port (ignored when fixed=1)
//   fixed in  1      1 selects fixed priority
//   any   out 1      at least one port is requesting
//   idx   out IDX_W  winning port index (0 when any=0)
module mem_arbiter_rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    input  logic             fixed,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

    logic [IDX_W-1:0] start;
    logic [N-1:0]     rotated;
    logic [IDX_W:0]   sum;

    // Duplicating the request vector and shifting right by the start index
    // puts the scan origin at bit 0 with wrap-around for free; the first set
    // bit k then maps back to port (start + k) mod N.
    always_comb begin
        start = '0;
        if (!fixed && (last != IDX_W'(N - 1))) begin
            start = last + IDX_W'(1);
        end
        rotated = N'({req, req} >> start);
        any     = 1'b0;
        idx     = '0;
        sum     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any && rotated[k]) begin
                any = 1'b1;
                sum = {1'b0, start} + (IDX_W+1)'(k);
                idx = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   N-port cacheline memory arbiter in front of a single cacheline adaptor.
//   One transaction at a time; the winner's op, address and write line are
//   captured at grant so the adaptor sees stable values until mem_resp.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_read/req_write  per-port level requests, held until req_resp
//   req_address         port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata           port p at [p*LINE_WIDTH +: LINE_WIDTH]
//   req_rdata           read line, shared by all ports (mem_rdata pass-through)
//   req_resp            one-cycle completion pulse to the granted port
//   mem_read/mem_write  request to adaptor while a transaction is in flight
//   mem_address/wdata   captured address / write line of the granted port
//   mem_rdata/mem_resp  adaptor read line and completion pulse
//   grant_valid         transaction in flight
//   grant_idx           index of the port being served
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter  int unsigned NUM_PORTS      = 2,
    parameter  int unsigned LINE_WIDTH     = 256,
    parameter  int unsigned ADDR_WIDTH     = 32,
    parameter  bit          FIXED_PRIORITY = 1'b0,
    localparam int unsigned IDX_W          = arb_idx_width(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [LINE_WIDTH-1:0]           mem_wdata,
    input  logic [LINE_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_resp,
    output logic                            grant_valid,
    output logic [IDX_W-1:0]                grant_idx
);

    arb_state_t state, next_state;
    arb_op_t    op;

    logic [IDX_W-1:0]      last_grant;
    logic [NUM_PORTS-1:0]  req_any;
    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];

    assign req_any = req_read | req_write;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            addr_arr[p]  = req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[p] = req_wdata[p*LINE_WIDTH +: LINE_WIDTH];
        end
    end

    mem_arbiter_rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_any),
        .last  (last_grant),
        .fixed (FIXED_PRIORITY),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (pick_any) next_state = ARB_BUSY;
            ARB_BUSY: if (mem_resp) next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    // Capture happens only on the IDLE->BUSY edge; the port inputs are not
    // looked at again until the transaction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op          <= ARB_OP_NONE;
            grant_idx   <= '0;
            last_grant  <= IDX_W'(NUM_PORTS - 1);
            mem_address <= '0;
            mem_wdata   <= '0;
        end else if (state == ARB_IDLE && pick_any) begin
            // read+write together is illegal; write takes precedence
            op          <= req_write[pick_idx] ? ARB_OP_WRITE : ARB_OP_READ;
            grant_idx   <= pick_idx;
            mem_address <= addr_arr[pick_idx];
            mem_wdata   <= wdata_arr[pick_idx];
            if (!FIXED_PRIORITY) begin
                last_grant <= pick_idx;
            end
        end
    end

    always_comb begin
        grant_valid = (state == ARB_BUSY);
        mem_read    = (state == ARB_BUSY) && (op == ARB_OP_READ);
        mem_write   = (state == ARB_BUSY) && (op == ARB_OP_WRITE);
        req_rdata   = mem_rdata;
        req_resp    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            req_resp[p] = (state == ARB_BUSY) && mem_resp && (grant_idx == IDX_W'(p));
        end
    end

endmodule
